// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: single-cycle ALU/branch ops plus an iterative shift-add
// signed multiply, valid/ready on both sides, ECALL parks the unit in HALT until reset.
module alu_exec_unit #(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [5:0]      ALUControl,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] Result,
   output logic            Zero,
   output logic            BranchTaken,
   output logic            Illegal,
   output logic            Halt
);
   localparam int ITERS = XLEN / MUL_BITS;
   localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;

   localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_MUL = 6'b000010,
                          OP_AND = 6'b000011, OP_OR  = 6'b000100, OP_XOR = 6'b000101,
                          OP_SRL = 6'b000110, OP_SLL = 6'b000111, OP_BGE = 6'b001000,
                          OP_BEQ = 6'b001001, OP_BNE = 6'b001010, OP_BLT = 6'b001011,
                          OP_SLT = 6'b001100, OP_ECALL = 6'b111111;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE, S_HALT} state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_result;
   logic            r_br, r_ill, r_ecall, r_halt;
   logic [XLEN-1:0] r_mul_a, r_mul_b, r_acc;
   logic [CW-1:0]   r_cnt;

   logic [XLEN-1:0] w_res, w_pp, w_acc_nxt;
   logic            w_br, w_ill, w_ecall, w_lt, w_eq, w_accept;
   logic [4:0]      w_shamt;

   assign w_lt    = $signed(SrcA) < $signed(SrcB);
   assign w_eq    = (SrcA == SrcB);
   assign w_shamt = SrcB[4:0];

   always_comb begin
      w_res   = '0;
      w_br    = 1'b0;
      w_ill   = 1'b0;
      w_ecall = 1'b0;
      case (ALUControl)
         OP_ADD:   w_res = SrcA + SrcB;
         OP_SUB:   w_res = SrcA - SrcB;
         OP_MUL:   w_res = '0;
         OP_AND:   w_res = SrcA & SrcB;
         OP_OR:    w_res = SrcA | SrcB;
         OP_XOR:   w_res = SrcA ^ SrcB;
         OP_SRL:   w_res = SrcA >> w_shamt;
         OP_SLL:   w_res = SrcA << w_shamt;
         OP_BGE:   w_br  = ~w_lt;
         OP_BEQ:   w_br  = w_eq;
         OP_BNE:   w_br  = ~w_eq;
         OP_BLT:   w_br  = w_lt;
         OP_SLT:   w_res = {{(XLEN-1){1'b0}}, w_lt};
         OP_ECALL: w_ecall = 1'b1;
         default:  w_ill = 1'b1;
      endcase
   end

   // Low XLEN bits of a two's-complement product equal the unsigned product, so
   // the engine treats B as unsigned digits of MUL_BITS each.
   assign w_pp      = r_mul_a * XLEN'(r_mul_b[MUL_BITS-1:0]);
   assign w_acc_nxt = r_acc + w_pp;

   always_comb begin
      case (r_state)
         S_IDLE:  in_ready = 1'b1;
         S_DONE:  in_ready = out_ready & ~r_ecall;
         default: in_ready = 1'b0;
      endcase
   end

   assign w_accept    = in_valid & in_ready;
   assign out_valid   = (r_state == S_DONE);
   assign Result      = r_result;
   assign Zero        = (r_result == '0);
   assign BranchTaken = r_br;
   assign Illegal     = r_ill;
   assign Halt        = r_halt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_result <= '0;
         r_br     <= 1'b0;
         r_ill    <= 1'b0;
         r_ecall  <= 1'b0;
         r_halt   <= 1'b0;
         r_mul_a  <= '0;
         r_mul_b  <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (r_state == S_DONE && out_ready && r_ecall) begin
                  r_state <= S_HALT;
                  r_halt  <= 1'b1;
               end else if (w_accept) begin
                  if (ALUControl == OP_MUL) begin
                     r_mul_a <= SrcA;
                     r_mul_b <= SrcB;
                     r_acc   <= '0;
                     r_cnt   <= CW'(ITERS - 1);
                     r_state <= S_MUL;
                  end else begin
                     r_result <= w_res;
                     r_br     <= w_br;
                     r_ill    <= w_ill;
                     r_ecall  <= w_ecall;
                     r_state  <= S_DONE;
                  end
               end else if (r_state == S_DONE && out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            S_MUL: begin
               r_acc   <= w_acc_nxt;
               r_mul_a <= r_mul_a << MUL_BITS;
               r_mul_b <= r_mul_b >> MUL_BITS;
               if (r_cnt == '0) begin
                  r_result <= w_acc_nxt;
                  r_br     <= 1'b0;
                  r_ill    <= 1'b0;
                  r_ecall  <= 1'b0;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table of single-cycle ops plus hand-written
// multiply, backpressure, reset-mid-multiply and ecall sequences.
module tb_alu_exec_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0, in_valid4 = 1'b0;
   logic        in_ready, in_ready4;
   logic [5:0]  ALUControl = '0;
   logic [31:0] SrcA = '0, SrcB = '0;
   logic        out_valid, out_valid4;
   logic        out_ready = 1'b1;
   logic [31:0] Result, Result4;
   logic        Zero, BranchTaken, Illegal, Halt;
   logic        Zero4, BranchTaken4, Illegal4, Halt4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_exec_unit #(.XLEN(32), .MUL_BITS(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
      .out_valid(out_valid), .out_ready(out_ready), .Result(Result), .Zero(Zero),
      .BranchTaken(BranchTaken), .Illegal(Illegal), .Halt(Halt));

   alu_exec_unit #(.XLEN(32), .MUL_BITS(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
      .out_valid(out_valid4), .out_ready(1'b1), .Result(Result4), .Zero(Zero4),
      .BranchTaken(BranchTaken4), .Illegal(Illegal4), .Halt(Halt4));

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [31:0] a, b, res;
      logic        br, ill, z;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int cyc;
      vecs[0]  = '{"sub",    6'b000001, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{"sll31",  6'b000111, 32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{"srl31",  6'b000110, 32'h80000000, 32'd31,       32'd1,        1'b0, 1'b0, 1'b0};
      vecs[3]  = '{"slt",    6'b001100, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0};
      vecs[4]  = '{"addwrap",6'b000000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 1'b0, 1'b1};
      vecs[5]  = '{"and",    6'b000011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{"or",     6'b000100, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{"xor",    6'b000101, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{"sllmask",6'b000111, 32'd3,        32'h00000021, 32'd6,        1'b0, 1'b0, 1'b0};
      vecs[9]  = '{"beq",    6'b001001, 32'd4,        32'd4,        32'd0,        1'b1, 1'b0, 1'b1};
      vecs[10] = '{"bne",    6'b001010, 32'd4,        32'd4,        32'd0,        1'b0, 1'b0, 1'b1};
      vecs[11] = '{"blt",    6'b001011, 32'hFFFFFFFB, 32'd2,        32'd0,        1'b1, 1'b0, 1'b1};
      vecs[12] = '{"bge",    6'b001000, 32'hFFFFFFFB, 32'd2,        32'd0,        1'b0, 1'b0, 1'b1};
      vecs[13] = '{"illegal",6'b010101, 32'd9,        32'd9,        32'd0,        1'b0, 1'b1, 1'b1};
      vecs[14] = '{"slt0",   6'b001100, 32'd5,        32'd3,        32'd0,        1'b0, 1'b0, 1'b1};

      // reset state
      #12;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready",  {31'b0, in_ready},  32'd1);
      check("rst_result",    Result,             32'd0);
      check("rst_zero",      {31'b0, Zero},      32'd1);
      check("rst_flags",     {29'b0, BranchTaken, Illegal, Halt}, 32'd0);
      rst = 1'b0;
      step();

      // back-to-back single-cycle vectors, one result per cycle
      out_ready = 1'b1;
      foreach (vecs[i]) begin
         in_valid = 1'b1; ALUControl = vecs[i].op; SrcA = vecs[i].a; SrcB = vecs[i].b;
         check({vecs[i].name, "_in_ready"}, {31'b0, in_ready}, 32'd1);
         step();
         check({vecs[i].name, "_valid"},  {31'b0, out_valid},   32'd1);
         check({vecs[i].name, "_result"}, Result,               vecs[i].res);
         check({vecs[i].name, "_br"},     {31'b0, BranchTaken}, {31'b0, vecs[i].br});
         check({vecs[i].name, "_ill"},    {31'b0, Illegal},     {31'b0, vecs[i].ill});
         check({vecs[i].name, "_zero"},   {31'b0, Zero},        {31'b0, vecs[i].z});
      end
      in_valid = 1'b0;
      step();
      check("drain_valid", {31'b0, out_valid}, 32'd0);

      // multiply, MUL_BITS=1: 32 cycles
      in_valid = 1'b1; ALUControl = 6'b000010; SrcA = 32'hFFFFFFFD; SrcB = 32'd7;
      step();
      in_valid = 1'b0; SrcA = 32'd0; SrcB = 32'd0;
      check("mul_busy_in_ready", {31'b0, in_ready}, 32'd0);
      cyc = 0;
      while (!out_valid && cyc < 40) begin step(); cyc++; end
      check("mul_latency", cyc, 32'd32);
      check("mul_result", Result, 32'hFFFFFFEB);
      step();

      // multiply, MUL_BITS=4: 8 cycles
      in_valid4 = 1'b1; ALUControl = 6'b000010; SrcA = 32'hFFFFFFFD; SrcB = 32'd7;
      step();
      in_valid4 = 1'b0;
      cyc = 0;
      while (!out_valid4 && cyc < 40) begin step(); cyc++; end
      check("mul4_latency", cyc, 32'd8);
      check("mul4_result", Result4, 32'hFFFFFFEB);
      step();

      // negative multiplier
      in_valid = 1'b1; ALUControl = 6'b000010; SrcA = 32'd6; SrcB = 32'hFFFFFFFE;
      step();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 40) begin step(); cyc++; end
      check("mulneg_result", Result, 32'hFFFFFFF4);
      step();

      // backpressure: result held, new request ignored until out_ready
      out_ready = 1'b0;
      in_valid = 1'b1; ALUControl = 6'b000000; SrcA = 32'd10; SrcB = 32'd20;
      step();
      ALUControl = 6'b000001; SrcA = 32'd100; SrcB = 32'd1;
      for (int k = 0; k < 5; k++) begin
         check("bp_valid",    {31'b0, out_valid}, 32'd1);
         check("bp_result",   Result,             32'd30);
         check("bp_in_ready", {31'b0, in_ready},  32'd0);
         step();
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("bp_next_result", Result, 32'd99);
      check("bp_next_valid",  {31'b0, out_valid}, 32'd1);
      step();

      // reset mid-multiply
      in_valid = 1'b1; ALUControl = 6'b000010; SrcA = 32'd7; SrcB = 32'd9;
      step();
      in_valid = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      #1;
      check("rstmul_valid",    {31'b0, out_valid}, 32'd0);
      check("rstmul_in_ready", {31'b0, in_ready},  32'd1);
      check("rstmul_halt",     {31'b0, Halt},      32'd0);
      #1 rst = 1'b0;
      in_valid = 1'b1; ALUControl = 6'b000000; SrcA = 32'd1; SrcB = 32'd2;
      step();
      in_valid = 1'b0;
      check("rstmul_add_valid",  {31'b0, out_valid}, 32'd1);
      check("rstmul_add_result", Result, 32'd3);
      step();

      // ecall
      out_ready = 1'b0;
      in_valid = 1'b1; ALUControl = 6'b111111; SrcA = 32'd0; SrcB = 32'd0;
      step();
      in_valid = 1'b0;
      check("ecall_valid",    {31'b0, out_valid}, 32'd1);
      check("ecall_in_ready", {31'b0, in_ready},  32'd0);
      check("ecall_nohalt",   {31'b0, Halt},      32'd0);
      out_ready = 1'b1;
      #1;
      check("ecall_in_ready_or", {31'b0, in_ready}, 32'd0);
      step();
      check("halt_set",     {31'b0, Halt},      32'd1);
      check("halt_valid",   {31'b0, out_valid}, 32'd0);
      in_valid = 1'b1; ALUControl = 6'b000000; SrcA = 32'd1; SrcB = 32'd1;
      repeat (3) step();
      check("halt_stuck",   {31'b0, Halt},      32'd1);
      check("halt_ignore",  {31'b0, out_valid}, 32'd0);
      check("halt_inready", {31'b0, in_ready},  32'd0);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("halt_cleared", {31'b0, Halt},     32'd0);
      check("halt_rst_rdy", {31'b0, in_ready}, 32'd1);
      rst = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Multi-cycle execute unit that consumes the 6-bit ALUControl codes produced by the ALU decoder and returns results over a valid/ready handshake.
- Single-cycle ops (add/sub/logic/shift/compare/branch) complete in 1 cycle. Signed multiply runs an iterative shift-add engine.
- ECALL code halts the unit.
- Sits between decode/operand-fetch and writeback/branch resolution.

Parameters:
- XLEN, 32, operand/result width.
- MUL_BITS, 1, multiplier bits consumed per iteration. Legal values are 1, 2, 4. Multiply iterations = XLEN/MUL_BITS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  unit can accept a request this cycle.
- ALUControl  in  6  operation code.
- SrcA  in  XLEN  operand A.
- SrcB  in  XLEN  operand B; shift amount is SrcB[4:0].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- Result  out  XLEN  registered result.
- Zero  out  1  Result == 0.
- BranchTaken  out  1  branch condition true (branch codes only).
- Illegal  out  1  accepted code was unrecognised.
- Halt  out  1  sticky; set once an ECALL result has been consumed.

Behaviour:
- Codes:
  - 000000 add, 000001 sub, 000010 signed mul (low XLEN bits), 000011 and, 000100 or, 000101 xor.
  - 000110 srl (logical), 000111 sll.
  - 001000 bge, 001001 beq, 001010 bne, 001011 blt. All compares are signed.
  - 001100 slt (signed, Result = 1 or 0).
  - 111111 ecall.
  - Any other code: Result = 0, Illegal = 1.
- Branch codes: Result = 0, BranchTaken = condition. For all non-branch codes BranchTaken = 0.
- Add/sub/mul wrap modulo 2^XLEN. No overflow flag.
- States: IDLE, MUL, DONE, HALT.
- Reset (any state, any cycle, including mid-multiply):
  - state = IDLE; in_ready = 1.
  - out_valid, Result, Zero(=1 after reset, since Result = 0), BranchTaken, Illegal, Halt all = 0.
  - Multiply counter and accumulator cleared.
- Accept: in_valid & in_ready at edge N.
- IDLE, accept of a single-cycle code or ecall: Result and flags registered at edge N; state -> DONE; out_valid = 1 after edge N.
- IDLE, accept of mul: operands latched, accumulator = 0, counter = XLEN/MUL_BITS - 1; state -> MUL.
- MUL:
  - One iteration per cycle: accumulator += (A * B[MUL_BITS-1:0]); A <<= MUL_BITS; B >>= MUL_BITS.
  - On the iteration where counter == 0, Result is written and state -> DONE.
  - With default parameters, out_valid rises after edge N+32.
  - in_ready = 0 throughout.
- DONE:
  - out_valid = 1. Result and flags hold stable while out_ready = 0.
  - On out_ready with a non-ecall result: out_valid drops. If in_valid is also high, the new request is accepted in the same edge (back-to-back). in_ready = out_ready in DONE, except for an ecall result.
  - On out_ready with an ecall result: state -> HALT, Halt = 1, in_ready stays 0.
- HALT: in_ready = 0, out_valid = 0, Halt = 1. Only rst exits.
- in_valid while in_ready = 0 is ignored; the requester must hold its request.
- ALUControl, SrcA and SrcB are sampled only at the accept edge; later changes have no effect.
- Zero is derived from the registered Result and is valid whenever out_valid = 1.

Test Plan:
- Reset mid-multiply: accept mul 7 * 9; assert rst at cycle 10 -> out_valid = 0, in_ready = 1, Halt = 0 immediately. Next accept of add 1 + 2 -> Result = 3, one cycle later.
- Single-cycle ops with out_ready held at 1:
  - sub 5 - 7 -> 0xFFFFFFFE.
  - sll 1 by 31 -> 0x80000000.
  - srl 0x80000000 by 31 -> 1.
  - slt -1 < 1 -> 1.
  - All back-to-back, one result per cycle.
- Multiply: -3 * 7 -> Result 0xFFFFFFEB, out_valid exactly 32 cycles after accept. Repeat with MUL_BITS = 4 -> 8 cycles.
- Branches: beq 4,4 -> BranchTaken = 1, Zero = 1. bne 4,4 -> 0. blt -5,2 -> 1. bge -5,2 -> 0.
- Backpressure: out_ready = 0 for 5 cycles after an add -> Result stable, in_ready = 0, and a new in_valid is ignored until out_ready = 1.
- Illegal/ecall:
  - Code 010101 -> Illegal = 1, Result = 0.
  - Ecall -> out_valid = 1; once consumed, Halt = 1 and in_ready = 0 permanently until rst.
